// File: rtl/lif_pkg.sv
// Shared constants, FSM encoding and arithmetic helpers for the time-multiplexed
// LIF neuron scheduler and its update core.
package lif_pkg;

    localparam logic [7:0] THR_INIT = 8'd100;
    localparam logic [7:0] THR_MAX  = 8'd220;
    localparam logic [7:0] THR_MIN  = 8'd8;

    localparam int DECAY_SHIFT   = 3;
    localparam int THR_INC_SHIFT = 3;
    localparam int THR_DEC_SHIFT = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fsm_t;

    // 8-bit unsigned add clamped at 255.
    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/lif_tdm_scheduler_core.sv
// Combinational LIF update for one neuron: spike test on the pre-update state,
// leaky integration with saturation, and optional threshold adaptation.
module lif_update_core
    import lif_pkg::*;
(
    input  logic [7:0] state_i,
    input  logic [7:0] thr_i,
    input  logic [7:0] cur_i,
    input  logic       learnable_i,
    output logic       spike_o,
    output logic [7:0] next_state_o,
    output logic [7:0] next_thr_o
);

    logic [9:0] acc_s;

    // Spike decision and next-state/threshold selection.
    always_comb begin
        acc_s        = {2'b00, cur_i} + {2'b00, state_i} - {2'b00, (state_i >> DECAY_SHIFT)};
        spike_o      = (state_i >= thr_i);
        next_state_o = state_i;
        next_thr_o   = thr_i;
        if (spike_o) begin
            next_state_o = 8'd0;
            // Below THR_MAX the increment cannot overflow 8 bits.
            if (learnable_i && (thr_i < THR_MAX)) begin
                next_thr_o = thr_i + (thr_i >> THR_INC_SHIFT);
            end else begin
                next_thr_o = thr_i;
            end
        end else begin
            next_state_o = (acc_s > 10'd255) ? 8'hFF : acc_s[7:0];
            if (learnable_i && (thr_i > THR_MIN)) begin
                next_thr_o = thr_i - (thr_i >> THR_DEC_SHIFT);
            end else begin
                next_thr_o = thr_i;
            end
        end
    end

endmodule

// File: rtl/lif_tdm_scheduler.sv
// Sweeps N_NEURONS virtual LIF neurons through one shared update core per time
// step and emits one address-event per spike over a single-entry valid/ready slot.
module lif_tdm_scheduler
    import lif_pkg::*;
#(
    parameter int N_NEURONS = 8,
    parameter int IDX_W     = $clog2(N_NEURONS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             learnable_threshold,
    input  logic             step_start,
    output logic             busy,
    output logic             step_done,
    input  logic             cur_we,
    input  logic [IDX_W-1:0] cur_addr,
    input  logic [7:0]       cur_data,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [IDX_W-1:0] ev_addr,
    output logic [7:0]       spike_count
);

    fsm_t             fsm_q, fsm_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       run_cnt_q, run_cnt_d;
    logic [7:0]       spike_count_q, spike_count_d;
    logic             ev_valid_q, ev_valid_d;
    logic [IDX_W-1:0] ev_addr_q, ev_addr_d;
    logic             busy_q;
    logic             step_done_q;

    logic [7:0] mem_state_q [N_NEURONS];
    logic [7:0] thr_q       [N_NEURONS];
    logic [7:0] cur_q       [N_NEURONS];

    logic       spike_s;
    logic [7:0] core_state_s;
    logic [7:0] core_thr_s;
    logic       slot_free_s;
    logic       proc_s;
    logic       last_s;
    logic       cur_accept_s;
    logic [7:0] cur_sum_s;

    lif_update_core u_core (
        .state_i      (mem_state_q[idx_q]),
        .thr_i        (thr_q[idx_q]),
        .cur_i        (cur_q[idx_q]),
        .learnable_i  (learnable_threshold),
        .spike_o      (spike_s),
        .next_state_o (core_state_s),
        .next_thr_o   (core_thr_s)
    );

    // A spiking neuron needs the event slot; a non-spiking one always proceeds.
    always_comb begin
        slot_free_s  = (!ev_valid_q) || ev_ready;
        proc_s       = (fsm_q == ST_RUN) && ((!spike_s) || slot_free_s);
        last_s       = (idx_q == IDX_W'(N_NEURONS - 1));
        cur_accept_s = cur_we && (!busy_q) && (int'(cur_addr) < N_NEURONS);
        cur_sum_s    = sat_add8(cur_q[cur_addr], cur_data);
    end

    // Sweep FSM next-state, neuron index and running spike count.
    always_comb begin
        fsm_d         = fsm_q;
        idx_d         = idx_q;
        run_cnt_d     = run_cnt_q;
        spike_count_d = spike_count_q;
        case (fsm_q)
            ST_IDLE: begin
                if (step_start) begin
                    fsm_d     = ST_RUN;
                    idx_d     = {IDX_W{1'b0}};
                    run_cnt_d = 8'd0;
                end else begin
                    fsm_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (proc_s) begin
                    if (spike_s && (run_cnt_q != 8'hFF)) begin
                        run_cnt_d = run_cnt_q + 8'd1;
                    end else begin
                        run_cnt_d = run_cnt_q;
                    end
                    if (last_s) begin
                        fsm_d = ST_DRAIN;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    fsm_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (slot_free_s) begin
                    fsm_d = ST_DONE;
                end else begin
                    fsm_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                fsm_d         = ST_IDLE;
                spike_count_d = run_cnt_q;
            end
            default: begin
                fsm_d = ST_IDLE;
            end
        endcase
    end

    // Event slot: cleared by a handshake, reloaded in the same cycle by a processed spike.
    always_comb begin
        ev_valid_d = ev_valid_q;
        ev_addr_d  = ev_addr_q;
        if (ev_valid_q && ev_ready) begin
            ev_valid_d = 1'b0;
        end else begin
            ev_valid_d = ev_valid_q;
        end
        if (proc_s && spike_s) begin
            ev_valid_d = 1'b1;
            ev_addr_d  = idx_q;
        end else begin
            ev_addr_d = ev_addr_q;
        end
    end

    // Control and output registers; busy/step_done follow the registered state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q         <= ST_IDLE;
            idx_q         <= {IDX_W{1'b0}};
            run_cnt_q     <= 8'd0;
            spike_count_q <= 8'd0;
            ev_valid_q    <= 1'b0;
            ev_addr_q     <= {IDX_W{1'b0}};
            busy_q        <= 1'b0;
            step_done_q   <= 1'b0;
        end else begin
            fsm_q         <= fsm_d;
            idx_q         <= idx_d;
            run_cnt_q     <= run_cnt_d;
            spike_count_q <= spike_count_d;
            ev_valid_q    <= ev_valid_d;
            ev_addr_q     <= ev_addr_d;
            busy_q        <= (fsm_d != ST_IDLE);
            step_done_q   <= (fsm_d == ST_DONE);
        end
    end

    // Per-neuron storage; writes happen only in IDLE, so they never race the sweep.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                mem_state_q[i] <= 8'd0;
                thr_q[i]       <= THR_INIT;
                cur_q[i]       <= 8'd0;
            end
        end else begin
            if (proc_s) begin
                mem_state_q[idx_q] <= core_state_s;
                thr_q[idx_q]       <= core_thr_s;
                cur_q[idx_q]       <= 8'd0;
            end else if (cur_accept_s) begin
                cur_q[cur_addr] <= cur_sum_s;
            end
        end
    end

    assign busy        = busy_q;
    assign step_done   = step_done_q;
    assign ev_valid    = ev_valid_q;
    assign ev_addr     = ev_addr_q;
    assign spike_count = spike_count_q;

endmodule

// File: tb/tb_lif_tdm_scheduler.sv
// Directed scoreboard bench for lif_tdm_scheduler with four neurons: expected
// event addresses are queued by the stimulus and checked by an independent monitor.
module tb_lif_tdm_scheduler;

    localparam int N   = 4;
    localparam int IW  = 2;
    localparam int LIM = 200;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          learnable_threshold = 1'b0;
    logic          step_start = 1'b0;
    logic          busy;
    logic          step_done;
    logic          cur_we = 1'b0;
    logic [IW-1:0] cur_addr = '0;
    logic [7:0]    cur_data = 8'd0;
    logic          ev_valid;
    logic          ev_ready = 1'b1;
    logic [IW-1:0] ev_addr;
    logic [7:0]    spike_count;

    int n_cmp = 0;
    int n_err = 0;
    int exp_q[$];

    lif_tdm_scheduler #(.N_NEURONS(N), .IDX_W(IW)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .learnable_threshold (learnable_threshold),
        .step_start          (step_start),
        .busy                (busy),
        .step_done           (step_done),
        .cur_we              (cur_we),
        .cur_addr            (cur_addr),
        .cur_data            (cur_data),
        .ev_valid            (ev_valid),
        .ev_ready            (ev_ready),
        .ev_addr             (ev_addr),
        .spike_count         (spike_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every accepted event is compared with the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && ev_valid && ev_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL ev_unexpected: got addr %0d expected no event", ev_addr);
            end else begin
                check("ev_addr", int'(ev_addr), exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic write_cur(input int a, input int d);
        cur_we   = 1'b1;
        cur_addr = IW'(a);
        cur_data = 8'(d);
        tick();
        cur_we   = 1'b0;
    endtask

    // Waits for the sweep to finish; returns busy cycles and step_done pulses seen.
    task automatic wait_done(output int cycles, output int dones);
        int guard = 0;
        cycles = 0;
        dones  = 0;
        while (busy && guard < LIM) begin
            cycles++;
            if (step_done) dones++;
            tick();
            guard++;
        end
        check("sweep_timeout", int'(guard < LIM), 1);
    endtask

    task automatic run_step(input logic learn, input int exp_cycles);
        int cyc;
        int dn;
        learnable_threshold = learn;
        step_start = 1'b1;
        tick();
        step_start = 1'b0;
        wait_done(cyc, dn);
        check("step_done_pulses", dn, 1);
        if (exp_cycles > 0) check("busy_cycles", cyc, exp_cycles);
    endtask

    task automatic check_reset_arrays(input string tag);
        for (int i = 0; i < N; i++) begin
            check({tag, "_thr"}, int'(dut.thr_q[i]), 100);
            check({tag, "_state"}, int'(dut.mem_state_q[i]), 0);
        end
    endtask

    initial begin
        int st_exp[4];
        int cnt_exp[4];
        int cyc;
        int dn;
        st_exp  = '{50, 94, 133, 0};
        cnt_exp = '{0, 0, 0, 1};

        // Reset values
        tick();
        tick();
        rst_n = 1'b1;
        check("rst_busy", int'(busy), 0);
        check("rst_step_done", int'(step_done), 0);
        check("rst_ev_valid", int'(ev_valid), 0);
        check("rst_ev_addr", int'(ev_addr), 0);
        check("rst_spike_count", int'(spike_count), 0);
        check_reset_arrays("rst");

        // Integration: 0 -> 50 -> 94 -> 133 -> spike; adaptation enabled on the spiking step
        for (int s = 0; s < 4; s++) begin
            write_cur(0, 50);
            if (s == 3) exp_q.push_back(0);
            run_step(s == 3, N + 2);
            check("int_state0", int'(dut.mem_state_q[0]), st_exp[s]);
            check("int_spike_count", int'(spike_count), cnt_exp[s]);
        end
        check("int_thr0", int'(dut.thr_q[0]), 112);
        check("int_thr1", int'(dut.thr_q[1]), 94);

        // Leak-only threshold decay and its floor
        do_reset();
        run_step(1'b1, N + 2);
        for (int i = 0; i < N; i++) check("leak_thr", int'(dut.thr_q[i]), 94);
        write_cur(1, 94);
        run_step(1'b0, N + 2);
        check("leak_state1", int'(dut.mem_state_q[1]), 94);
        exp_q.push_back(1);
        run_step(1'b0, N + 2);
        check("leak_spike_at_94", int'(spike_count), 1);
        for (int k = 0; k < 50; k++) run_step(1'b1, N + 2);
        for (int i = 0; i < N; i++) check("thr_floor", int'(dut.thr_q[i]), 15);

        // Saturation of current and membrane state
        do_reset();
        write_cur(2, 99);
        run_step(1'b0, N + 2);
        check("sat_state_99", int'(dut.mem_state_q[2]), 99);
        write_cur(2, 200);
        write_cur(2, 100);
        check("sat_cur", int'(dut.cur_q[2]), 255);
        run_step(1'b0, N + 2);
        check("sat_state_255", int'(dut.mem_state_q[2]), 255);
        check("sat_no_spike", int'(spike_count), 0);
        exp_q.push_back(2);
        run_step(1'b0, N + 2);
        check("sat_spike", int'(spike_count), 1);
        check("sat_state_after", int'(dut.mem_state_q[2]), 0);

        // Backpressure: event 1 held, sweep stalls on neuron 2
        do_reset();
        write_cur(1, 150);
        write_cur(2, 120);
        run_step(1'b0, N + 2);
        ev_ready = 1'b0;
        exp_q.push_back(1);
        exp_q.push_back(2);
        step_start = 1'b1;
        tick();
        step_start = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        check("bp_idx", int'(dut.idx_q), 2);
        check("bp_ev_valid", int'(ev_valid), 1);
        check("bp_ev_addr", int'(ev_addr), 1);
        check("bp_busy", int'(busy), 1);
        check("bp_state2_held", int'(dut.mem_state_q[2]), 120);
        ev_ready = 1'b1;
        wait_done(cyc, dn);
        check("bp_step_done", dn, 1);
        check("bp_spike_count", int'(spike_count), 2);
        check("bp_queue_drained", exp_q.size(), 0);

        // Command rules while busy
        do_reset();
        step_start = 1'b1;
        tick();
        dn = 0;
        cyc = 0;
        cur_we   = 1'b1;
        cur_addr = IW'(3);
        cur_data = 8'd200;
        while (busy && cyc < LIM) begin
            if (step_done) dn++;
            tick();
            cyc++;
        end
        step_start = 1'b0;
        cur_we     = 1'b0;
        check("cmd_timeout", int'(cyc < LIM), 1);
        check("cmd_single_done", dn, 1);
        tick();
        tick();
        check("cmd_no_restart", int'(busy), 0);
        check("cmd_cur_dropped", int'(dut.cur_q[3]), 0);

        // Reset in the middle of a sweep with a pending event
        do_reset();
        write_cur(0, 150);
        run_step(1'b0, N + 2);
        ev_ready = 1'b0;
        step_start = 1'b1;
        tick();
        step_start = 1'b0;
        tick();
        tick();
        check("mid_pre_ev_valid", int'(ev_valid), 1);
        rst_n = 1'b0;
        tick();
        check("mid_ev_valid", int'(ev_valid), 0);
        check("mid_busy", int'(busy), 0);
        check("mid_ev_addr", int'(ev_addr), 0);
        check_reset_arrays("mid");
        rst_n = 1'b1;
        ev_ready = 1'b1;
        tick();

        check("final_queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
